serial_adder_fsm: RTL



---
 rtl/serial_adder_fsm.sv | 106 ++++++++++
 1 files changed

// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first, start/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output Ovf.
module serial_adder_fsm #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] psum_q;
    logic             c_q;
    logic [CntW-1:0]  cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic             sa_q;
    logic             sb_q;
`endif

    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] sum_final;

    assign sum_bit    = ra_q[0] ^ rb_q[0] ^ c_q;
    assign carry_next = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);
    // Partial sum with this cycle's bit inserted; complete on the last SHIFT cycle.
    assign sum_final  = {sum_bit, psum_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ra_q    <= '0;
            rb_q    <= '0;
            psum_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            S       <= '0;
            Cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            Ovf     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        ra_q    <= A;
                        rb_q    <= B;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StShift;
`ifdef SERIAL_ADDER_OVF_EN
                        sa_q    <= A[WIDTH-1];
                        sb_q    <= B[WIDTH-1];
`endif
                    end
                end
                StShift: begin
                    ra_q   <= ra_q >> 1;
                    rb_q   <= rb_q >> 1;
                    psum_q <= sum_final;
                    c_q    <= carry_next;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        S       <= sum_final;
                        Cout    <= carry_next;
                        done    <= 1'b1;
                        state_q <= StDone;
`ifdef SERIAL_ADDER_OVF_EN
                        // sum_bit is the final sum MSB here.
                        Ovf     <= (sa_q == sb_q) && (sum_bit != sa_q);
`endif
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
